// File: rtl/ue14500_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ue14500_pkg
//  Purpose  : Shared defaults, sequencer state encoding and the stack-pointer
//             width helper used by the UE14500 program sequencer.
//  Contents : ADDR_W_DEF, DEPTH_DEF, SP_W_DEF, sp_width(), seq_state_t
//  Revision : 1.0 - initial release
// ============================================================================
package ue14500_pkg;

    // Pointer needs one bit beyond the index so "full" (== DEPTH) is encodable.
    function automatic int sp_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int ADDR_W_DEF = 6;
    localparam int DEPTH_DEF  = 4;
    localparam int SP_W_DEF   = sp_width(DEPTH_DEF);

    // START: out of reset, first edge only arms fetch.
    // RUN  : fetching and sequencing.
    // HALT : everything frozen until run_i.
    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2
    } seq_state_t;

endpackage : ue14500_pkg
`default_nettype wire

// File: rtl/ue14500_seq_stack.sv
`default_nettype none
// ============================================================================
//  Module   : ue14500_seq_stack
//  Purpose  : Return-address LIFO for the UE14500 sequencer.
//  Ports    : clk, rst          - clock, async active-high reset (empties)
//             push_i, data_i    - push data_i (ignored when full)
//             pop_i             - discard top entry (ignored when empty)
//             top_o             - current top-of-stack entry
//             full_o, empty_o   - occupancy status
//  Revision : 1.0 - initial release
// ============================================================================
module ue14500_seq_stack
    import ue14500_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [ADDR_W-1:0] data_i,
    output logic [ADDR_W-1:0] top_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int SP_W  = sp_width(DEPTH);
    localparam int IDX_W = SP_W - 1;

    logic [SP_W-1:0]   sp_q;
    logic [SP_W-1:0]   sp_d;
    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [IDX_W-1:0]  w_wr_idx;
    logic [IDX_W-1:0]  w_rd_idx;
    logic              w_do_push;
    logic              w_do_pop;

    assign full_o    = (sp_q == SP_W'(DEPTH));
    assign empty_o   = (sp_q == '0);
    assign w_do_push = push_i && !full_o;
    assign w_do_pop  = pop_i && !empty_o && !push_i;

    // When full, the low index bits wrap to 0, but writes are blocked then.
    assign w_wr_idx = sp_q[IDX_W-1:0];
    assign w_rd_idx = w_wr_idx - IDX_W'(1);
    assign top_o    = mem_q[w_rd_idx];

    always_comb begin
        sp_d = sp_q;
        if (w_do_push) begin
            sp_d = sp_q + SP_W'(1);
        end else if (w_do_pop) begin
            sp_d = sp_q - SP_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    // Entry storage needs no reset: only entries below sp_q are ever read.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            mem_q[w_wr_idx] <= data_i;
        end
    end

endmodule : ue14500_seq_stack
`default_nettype wire

// File: rtl/ue14500_seq.sv
`default_nettype none
// ============================================================================
//  Module   : ue14500_seq
//  Purpose  : Program sequencer for a UE14500-style 1-bit core: increment,
//             jump, call/return, halt and resume. Return stack is present
//             only when UE14500_SEQ_STACK_EN is defined; otherwise RTN
//             returns to address 0 and the overflow/underflow flags read 0.
//  Ports    : clk, rst                    - clock, async active-high reset
//             jmp_i, rtn_i, flg0_i, flgf_i - decoded core events
//             run_i                       - resume from halt
//             tgt_i                       - jump target
//             pc_o, fetch_o               - next fetch address / valid
//             halted_o, ovf_o, unf_o      - status (flags sticky)
//  Revision : 1.0 - initial release
// ============================================================================
module ue14500_seq
    import ue14500_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jmp_i,
    input  logic              rtn_i,
    input  logic              flg0_i,
    input  logic              flgf_i,
    input  logic              run_i,
    input  logic [ADDR_W-1:0] tgt_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              fetch_o,
    output logic              halted_o,
    output logic              ovf_o,
    output logic              unf_o
);

    seq_state_t        state_q;
    seq_state_t        state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic              fetch_q;
    logic              halted_q;
    logic [ADDR_W-1:0] w_pc_inc;

    assign w_pc_inc = pc_q + ADDR_W'(1);

`ifdef UE14500_SEQ_STACK_EN
    logic              ovf_q;
    logic              ovf_d;
    logic              unf_q;
    logic              unf_d;
    logic              w_push;
    logic              w_pop;
    logic              w_stk_full;
    logic              w_stk_empty;
    logic [ADDR_W-1:0] w_stk_top;

    ue14500_seq_stack #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_stack (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .data_i  (w_pc_inc),
        .top_o   (w_stk_top),
        .full_o  (w_stk_full),
        .empty_o (w_stk_empty)
    );

    assign ovf_o = ovf_q;
    assign unf_o = unf_q;
`else
    // Without a stack the call qualifier has no meaning.
    logic unused_flg0;
    assign unused_flg0 = flg0_i;
    assign ovf_o       = 1'b0;
    assign unf_o       = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
`ifdef UE14500_SEQ_STACK_EN
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        w_push  = 1'b0;
        w_pop   = 1'b0;
`endif
        case (state_q)
            ST_START: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                // rtn beats jmp; a coincident jmp is simply dropped.
                if (rtn_i) begin
`ifdef UE14500_SEQ_STACK_EN
                    if (w_stk_empty) begin
                        unf_d = 1'b1;
                        pc_d  = w_pc_inc;
                    end else begin
                        w_pop = 1'b1;
                        pc_d  = w_stk_top;
                    end
`else
                    pc_d = '0;
`endif
                end else if (jmp_i) begin
                    pc_d = tgt_i;
`ifdef UE14500_SEQ_STACK_EN
                    // Overflowing call still jumps; the return address is lost.
                    if (flg0_i) begin
                        if (w_stk_full) begin
                            ovf_d = 1'b1;
                        end else begin
                            w_push = 1'b1;
                        end
                    end
`endif
                end else begin
                    pc_d = w_pc_inc;
                end
                if (flgf_i) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (run_i) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_START;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_START;
            pc_q     <= '0;
            fetch_q  <= 1'b0;
            halted_q <= 1'b0;
`ifdef UE14500_SEQ_STACK_EN
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            fetch_q  <= (state_d == ST_RUN);
            halted_q <= (state_d == ST_HALT);
`ifdef UE14500_SEQ_STACK_EN
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
`endif
        end
    end

    assign pc_o     = pc_q;
    assign fetch_o  = fetch_q;
    assign halted_o = halted_q;

endmodule : ue14500_seq
`default_nettype wire

// File: tb/tb_ue14500_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ue14500_seq
//  Purpose  : Self-checking bench for ue14500_seq. A behavioural model tracks
//             pc/fetch/halt/flags and an array-based return stack; a compare
//             process checks every cycle, and directed steps pin key values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ue14500_seq;

    localparam int AW = 6;
    localparam int DP = 4;
    localparam int PCMOD = 64;
`ifdef UE14500_SEQ_STACK_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    logic          clk    = 1'b0;
    logic          rst    = 1'b1;
    logic          jmp_i  = 1'b0;
    logic          rtn_i  = 1'b0;
    logic          flg0_i = 1'b0;
    logic          flgf_i = 1'b0;
    logic          run_i  = 1'b0;
    logic [AW-1:0] tgt_i  = '0;
    logic [AW-1:0] pc_o;
    logic          fetch_o;
    logic          halted_o;
    logic          ovf_o;
    logic          unf_o;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    ue14500_seq #(.ADDR_W(AW), .DEPTH(DP)) dut (
        .clk      (clk),
        .rst      (rst),
        .jmp_i    (jmp_i),
        .rtn_i    (rtn_i),
        .flg0_i   (flg0_i),
        .flgf_i   (flgf_i),
        .run_i    (run_i),
        .tgt_i    (tgt_i),
        .pc_o     (pc_o),
        .fetch_o  (fetch_o),
        .halted_o (halted_o),
        .ovf_o    (ovf_o),
        .unf_o    (unf_o)
    );

    // ---------------- behavioural model ----------------
    int m_pc    = 0;
    bit m_fetch = 1'b0;
    bit m_halt  = 1'b0;
    bit m_boot  = 1'b1;   // waiting for the first edge after reset
    bit m_ovf   = 1'b0;
    bit m_unf   = 1'b0;
    int m_sp    = 0;
    int m_stk [DP];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc <= 0; m_fetch <= 1'b0; m_halt <= 1'b0; m_boot <= 1'b1;
            m_ovf <= 1'b0; m_unf <= 1'b0; m_sp <= 0;
        end else if (m_boot) begin
            m_boot  <= 1'b0;
            m_fetch <= 1'b1;
        end else if (m_halt) begin
            if (run_i) begin
                m_halt  <= 1'b0;
                m_fetch <= 1'b1;
            end
        end else begin
            if (rtn_i) begin
                if (!STK) begin
                    m_pc <= 0;
                end else if (m_sp == 0) begin
                    m_unf <= 1'b1;
                    m_pc  <= (m_pc + 1) % PCMOD;
                end else begin
                    m_pc <= m_stk[m_sp-1];
                    m_sp <= m_sp - 1;
                end
            end else if (jmp_i) begin
                m_pc <= int'(tgt_i);
                if (STK && flg0_i) begin
                    if (m_sp == DP) begin
                        m_ovf <= 1'b1;
                    end else begin
                        m_stk[m_sp] <= (m_pc + 1) % PCMOD;
                        m_sp        <= m_sp + 1;
                    end
                end
            end else begin
                m_pc <= (m_pc + 1) % PCMOD;
            end
            if (flgf_i) begin
                m_halt  <= 1'b1;
                m_fetch <= 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // One compare per cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_pc",     32'(pc_o),     32'(m_pc));
            check("model_fetch",  32'(fetch_o),  32'(m_fetch));
            check("model_halted", 32'(halted_o), 32'(m_halt));
            check("model_ovf",    32'(ovf_o),    32'(m_ovf));
            check("model_unf",    32'(unf_o),    32'(m_unf));
        end
    end

    task automatic step(input bit j, input bit r, input bit f0, input bit ff,
                        input bit rn, input int t);
        jmp_i = j; rtn_i = r; flg0_i = f0; flgf_i = ff; run_i = rn; tgt_i = AW'(t);
        @(posedge clk);
        #2;
        jmp_i = 1'b0; rtn_i = 1'b0; flg0_i = 1'b0; flgf_i = 1'b0; run_i = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_pc"},     32'(pc_o),     32'd0);
        check({tag, "_fetch"},  32'(fetch_o),  32'd0);
        check({tag, "_halted"}, 32'(halted_o), 32'd0);
        check({tag, "_ovf"},    32'(ovf_o),    32'd0);
        check({tag, "_unf"},    32'(unf_o),    32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        check_reset("rst");
        chk_en = 1'b1;
        rst    = 1'b0;

        // Free-running count with wrap at 63.
        for (int k = 1; k <= 70; k++) begin
            step(0, 0, 0, 0, 0, 0);
            if (k == 1) begin
                check("boot_pc", 32'(pc_o), 32'd0);
                check("boot_fetch", 32'(fetch_o), 32'd1);
            end
            if (k == 2)  check("inc_pc1", 32'(pc_o), 32'd1);
            if (k == 64) check("inc_pc63", 32'(pc_o), 32'd63);
            if (k == 65) check("wrap_pc0", 32'(pc_o), 32'd0);
        end
        check("pc_before_call", 32'(pc_o), 32'd5);

        // Call at 5 to 20, run a little, return.
        step(1, 0, 1, 0, 0, 20);
        check("call_pc", 32'(pc_o), 32'd20);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check("callee_pc", 32'(pc_o), 32'd22);
        step(0, 1, 0, 0, 0, 0);
`ifdef UE14500_SEQ_STACK_EN
        check("rtn_pc", 32'(pc_o), 32'd6);
`else
        check("rtn_pc", 32'(pc_o), 32'd0);
`endif
        check("rtn_ovf", 32'(ovf_o), 32'd0);
        check("rtn_unf", 32'(unf_o), 32'd0);

        // Five nested calls, then five returns.
        step(1, 0, 1, 0, 0, 10);
        step(1, 0, 1, 0, 0, 20);
        step(1, 0, 1, 0, 0, 30);
        step(1, 0, 1, 0, 0, 40);
        check("nest4_ovf", 32'(ovf_o), 32'd0);
        step(1, 0, 1, 0, 0, 50);
        check("nest5_pc", 32'(pc_o), 32'd50);
`ifdef UE14500_SEQ_STACK_EN
        check("nest5_ovf", 32'(ovf_o), 32'd1);
        step(0, 1, 0, 0, 0, 0); check("unwind1", 32'(pc_o), 32'd31);
        step(0, 1, 0, 0, 0, 0); check("unwind2", 32'(pc_o), 32'd21);
        step(0, 1, 0, 0, 0, 0); check("unwind3", 32'(pc_o), 32'd11);
        step(0, 1, 0, 0, 0, 0); check("unwind4", 32'(pc_o), 32'd7);
        check("unwind4_unf", 32'(unf_o), 32'd0);
        step(0, 1, 0, 0, 0, 0); check("unwind5", 32'(pc_o), 32'd8);
        check("unwind5_unf", 32'(unf_o), 32'd1);
`else
        check("nest5_ovf", 32'(ovf_o), 32'd0);
        repeat (5) step(0, 1, 0, 0, 0, 0);
        check("unwind5", 32'(pc_o), 32'd0);
        check("unwind5_unf", 32'(unf_o), 32'd0);
`endif

        // Halt on a jump, ignore events while halted, resume.
        step(1, 0, 0, 1, 0, 9);
        check("halt_pc", 32'(pc_o), 32'd9);
        check("halt_halted", 32'(halted_o), 32'd1);
        check("halt_fetch", 32'(fetch_o), 32'd0);
        step(1, 1, 1, 1, 0, 30);
        check("halted_jmp_pc", 32'(pc_o), 32'd9);
        step(0, 0, 0, 0, 1, 0);
        check("resume_pc", 32'(pc_o), 32'd9);
        check("resume_fetch", 32'(fetch_o), 32'd1);
        step(0, 0, 0, 0, 0, 0);
        check("resume_inc", 32'(pc_o), 32'd10);
        step(0, 0, 0, 0, 1, 0);
        check("run_ignored_pc", 32'(pc_o), 32'd11);
        step(0, 0, 0, 1, 0, 0);
        check("halt2_pc", 32'(pc_o), 32'd12);
        step(0, 0, 0, 1, 1, 0);
        check("resume_wins", 32'(halted_o), 32'd0);
        step(0, 0, 0, 0, 0, 0);
        check("resume2_inc", 32'(pc_o), 32'd13);

        // rtn and jmp together with one stacked entry (12).
        step(1, 0, 0, 0, 0, 11);
        step(1, 0, 1, 0, 0, 40);
        check("call40_pc", 32'(pc_o), 32'd40);
        step(1, 1, 0, 0, 0, 50);
`ifdef UE14500_SEQ_STACK_EN
        check("rtn_beats_jmp", 32'(pc_o), 32'd12);
`else
        check("rtn_beats_jmp", 32'(pc_o), 32'd0);
`endif

        // Call from 63: return address wraps to 0.
        step(1, 0, 0, 0, 0, 63);
        step(1, 0, 1, 0, 0, 5);
        step(0, 0, 0, 0, 0, 0);
        check("wrap_callee", 32'(pc_o), 32'd6);
        step(0, 1, 0, 0, 0, 0);
        check("wrap_rtn", 32'(pc_o), 32'd0);

        // Reset while halted.
        step(0, 0, 0, 1, 0, 0);
        check("pre_rst_halt", 32'(halted_o), 32'd1);
        #1; rst = 1'b1; #1;
        check_reset("rst_halt");
        @(posedge clk); #2;
        rst = 1'b0;
        step(0, 0, 0, 0, 0, 0);
        check("reboot_fetch", 32'(fetch_o), 32'd1);
        step(0, 0, 0, 0, 0, 0);
        check("reboot_pc", 32'(pc_o), 32'd1);

        // Reset during a call: the push must not survive.
        jmp_i = 1'b1; flg0_i = 1'b1; tgt_i = AW'(33);
        #1; rst = 1'b1;
        @(posedge clk); #2;
        jmp_i = 1'b0; flg0_i = 1'b0;
        check_reset("rst_call");
        rst = 1'b0;
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
`ifdef UE14500_SEQ_STACK_EN
        check("post_rst_rtn_pc", 32'(pc_o), 32'd1);
        check("post_rst_rtn_unf", 32'(unf_o), 32'd1);
`else
        check("post_rst_rtn_pc", 32'(pc_o), 32'd0);
        check("post_rst_rtn_unf", 32'(unf_o), 32'd0);
`endif
        repeat (3) step(0, 0, 0, 0, 0, 0);

        @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_ue14500_seq
`default_nettype wire
